reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Parametrised successor to the single-output power-on reset counter.
- Generates NUM_CH active-low reset outputs after a programmable hold time and releases them in order, channel 0 first, with a fixed stagger between channels.
- Accepts three reset sources: the system reset, a debounced external pin and a software request.
- Reports which source caused the last reset and counts non-system resets.
- Sits at the top level, between the board clock/reset and the subsystem resets (JTAG UART, core logic, peripherals).

Parameters:
- NUM_CH, 4, number of sequenced reset outputs (must be >= 1).
- HOLD_CYCLES, 32, cycles all outputs stay asserted after the last active trigger (must be >= 1, < 2^CNT_W).
- STAGE_GAP, 16, cycles between release of channel k and channel k+1 (must be >= 1, < 2^CNT_W).
- DEBOUNCE, 8, consecutive synchronised-low cycles before the external pin counts as a request (must be >= 1, < 2^CNT_W).
- CNT_W, 8, width of the internal hold, gap and debounce counters.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high system reset.
- ext_nreset_i  in  1  asynchronous, active-low external reset pin.
- sw_reset_i  in  1  software reset request, synchronous to clk_i, level-sensitive.
- nreset_o  out  NUM_CH  per-channel active-low reset, registered.
- ready_o  out  1  high when all channels are released.
- cause_o  out  2  cause of the last reset: 00 system, 01 external pin, 10 software.
- reset_count_o  out  8  saturating count of external and software resets.

Behaviour:
- One clock; reset is synchronous and active-high. All state changes on the rising edge of clk_i.
- States: ASSERT, RELEASE, RUN.
- reset_i high at an edge:
  - state=ASSERT, hold_cnt=HOLD_CYCLES-1, stage=0.
  - nreset_o=all 0, ready_o=0, cause_o=00, reset_count_o=0.
  - Both synchroniser flops=1, debounce counter=0, ext_req=0.
  - reset_i has priority over every other input.
- External pin path:
  - Two-flop synchroniser, then debounce counter.
  - The counter increments while the synchronised pin is 0 and clears when it is 1.
  - ext_req=1 while the counter has reached DEBOUNCE-1 and the pin is still 0. The counter saturates there.
- Trigger = ext_req | sw_reset_i, evaluated only when reset_i is low.
- ASSERT:
  - nreset_o=0, ready_o=0.
  - While trigger=1, hold_cnt reloads to HOLD_CYCLES-1.
  - Otherwise hold_cnt decrements each cycle.
  - At an edge where hold_cnt==0 and trigger==0: nreset_o[0]<=1 and gap_cnt<=STAGE_GAP-1.
    - If NUM_CH==1: go to RUN and set ready_o<=1.
    - Otherwise: go to RELEASE with stage=1.
- RELEASE:
  - gap_cnt decrements each cycle.
  - At an edge where gap_cnt==0: nreset_o[stage]<=1, stage increments, gap_cnt reloads.
  - At the edge that releases channel NUM_CH-1: go to RUN and set ready_o<=1 on the same edge.
- RUN: all nreset_o=1, ready_o=1, holds.
- Trigger in RELEASE or RUN:
  - At the next edge: state=ASSERT, nreset_o=all 0, ready_o=0, hold_cnt=HOLD_CYCLES-1, stage=0.
  - Released channels re-assert together; there is no reverse sequencing.
- Trigger while already in ASSERT only reloads hold_cnt; no cause or count update.
- Cause and count update only on the ASSERT-entry edge from RELEASE or RUN:
  - cause_o=01 if ext_req, else 10. If both are set, external wins.
  - reset_count_o increments and saturates at 255.
  - cause_o is sticky until the next entry.
- Release timing from reset:
  - Let E0 be the last edge with reset_i=1 and no trigger after it.
  - nreset_o[k] rises at edge E0 + HOLD_CYCLES + k*STAGE_GAP.
  - ready_o rises together with nreset_o[NUM_CH-1].
- Invariant: nreset_o is always thermometer-coded, i.e. channel k released implies channels 0..k-1 are released.
- Power-up initial values (FPGA init) equal the reset values.

Test Plan:
- Defaults, reset_i high 3 cycles then low (last high edge E0) -> nreset_o[0..3] rise at E0+32, +48, +64, +80; ready_o rises at E0+80; cause_o=00; reset_count_o=0.
- In RUN, sw_reset_i high for 1 cycle -> next edge nreset_o=0000 and ready_o=0; nreset_o[0] rises 32 cycles after the edge where sw_reset_i is sampled high; cause_o=10; reset_count_o=1.
- In RUN, ext_nreset_i low for 5 cycles -> no reset. Low for 20 cycles -> reset asserts 2+8 cycles after the pin falls, hold extends until 32 cycles after ext_req drops; cause_o=01; reset_count_o increments.
- ext_nreset_i low and sw_reset_i high on the same entry edge -> cause_o=01, reset_count_o increments by exactly 1.
- Trigger in RELEASE after channel 1 is released -> next edge nreset_o=0000, stage restarts from channel 0, full hold repeats; reset_i pulse mid-RELEASE -> reset_count_o=0, cause_o=00.
- NUM_CH=1, HOLD_CYCLES=1, STAGE_GAP=1 -> nreset_o and ready_o rise at E0+1; 300 software resets -> reset_count_o saturates at 255.

Source files
------------

// File: rtl/reset_sequencer.sv
// Purpose: sequences NUM_CH active-low resets out of system, debounced-pin and software reset sources.
// Latency: outputs are registered; the first channel releases HOLD_CYCLES after the last trigger, then one channel every STAGE_GAP.
// Backpressure: none; any trigger re-asserts every channel on the next edge and restarts the hold.
module reset_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 32,
    parameter int STAGE_GAP   = 16,
    parameter int DEBOUNCE    = 8,
    parameter int CNT_W       = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ext_nreset_i,
    input  logic              sw_reset_i,
    output logic [NUM_CH-1:0] nreset_o,
    output logic              ready_o,
    output logic [1:0]        cause_o,
    output logic [7:0]        reset_count_o
);

    localparam int STG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE - 1);
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_CH - 1);

    localparam logic [1:0] CAUSE_SYS = 2'b00;
    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // Power-up values match the reset values so the FPGA starts in ASSERT.
    logic              sync1_q    = 1'b1;
    logic              sync2_q    = 1'b1;
    logic [CNT_W-1:0]  deb_cnt_q  = '0;
    logic [CNT_W-1:0]  deb_cnt_d;
    state_t            state_q    = ST_ASSERT;
    logic [CNT_W-1:0]  hold_cnt_q = HOLD_LD;
    logic [CNT_W-1:0]  gap_cnt_q  = '0;
    logic [STG_W-1:0]  stage_q    = '0;
    logic [NUM_CH-1:0] nreset_q   = '0;
    logic              ready_q    = 1'b0;
    logic [1:0]        cause_q    = CAUSE_SYS;
    logic [7:0]        count_q    = '0;

    logic ext_req;
    logic trigger;

    // Two-flop synchroniser for the asynchronous pin, followed by the debounce counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= ext_nreset_i;
            sync2_q   <= sync1_q;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Debounce counts synchronised-low cycles, clears on high, saturates at the request threshold.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        if (sync2_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_MAX) begin
            deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
    end

    // The pin request is live only while the pin is still low at the threshold, so release
    // timing tracks the pin going high rather than a stretched pulse.
    assign ext_req = !sync2_q && (deb_cnt_q == DEB_MAX);
    assign trigger = ext_req | sw_reset_i;

    // Sequencer FSM: hold all channels, then release them one by one, then run.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_ASSERT;
            hold_cnt_q <= HOLD_LD;
            gap_cnt_q  <= '0;
            stage_q    <= '0;
            nreset_q   <= '0;
            ready_q    <= 1'b0;
            cause_q    <= CAUSE_SYS;
            count_q    <= '0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    nreset_q <= '0;
                    ready_q  <= 1'b0;
                    if (trigger) begin
                        hold_cnt_q <= HOLD_LD;
                    end else if (hold_cnt_q == '0) begin
                        nreset_q  <= NUM_CH'(1);
                        gap_cnt_q <= GAP_LD;
                        if (NUM_CH == 1) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                            stage_q <= STG_W'(1);
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q - CNT_W'(1);
                    end
                end

                ST_RELEASE, ST_RUN: begin
                    if (trigger) begin
                        // Entry into ASSERT from a running system: all channels drop together.
                        state_q    <= ST_ASSERT;
                        nreset_q   <= '0;
                        ready_q    <= 1'b0;
                        hold_cnt_q <= HOLD_LD;
                        stage_q    <= '0;
                        cause_q    <= ext_req ? CAUSE_EXT : CAUSE_SW;
                        if (count_q != 8'hFF) begin
                            count_q <= count_q + 8'd1;
                        end
                    end else if (state_q == ST_RUN) begin
                        nreset_q <= '1;
                        ready_q  <= 1'b1;
                    end else if (gap_cnt_q == '0) begin
                        nreset_q[stage_q] <= 1'b1;
                        if (stage_q == LAST_STG) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            stage_q   <= stage_q + STG_W'(1);
                            gap_cnt_q <= GAP_LD;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - CNT_W'(1);
                    end
                end

                default: begin
                    state_q    <= ST_ASSERT;
                    nreset_q   <= '0;
                    ready_q    <= 1'b0;
                    hold_cnt_q <= HOLD_LD;
                    stage_q    <= '0;
                end
            endcase
        end
    end

    assign nreset_o      = nreset_q;
    assign ready_o       = ready_q;
    assign cause_o       = cause_q;
    assign reset_count_o = count_q;

endmodule
